// File: rtl/sequence_player.sv
// Plays a stored colour sequence on four LEDs: fetch a code, light its LED for the
// speed-selected on-time, stay dark for a gap, repeat until seq_len colours are shown.
module sequence_player #(
    parameter int COLOR_CODEFY_W = 2,
    parameter int ADDR_WIDTH     = 5,
    parameter int ON_CYCLES_SLOW = 4,
    parameter int ON_CYCLES_FAST = 2,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      speed,
    input  logic [ADDR_WIDTH:0]       seq_len,
    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [COLOR_CODEFY_W-1:0] mem_rd_data,
    output logic                      led_green,
    output logic                      led_red,
    output logic                      led_blue,
    output logic                      led_yellow,
    output logic                      busy,
    output logic                      done
);

    localparam int MAX_ON  = (ON_CYCLES_SLOW > ON_CYCLES_FAST) ? ON_CYCLES_SLOW : ON_CYCLES_FAST;
    localparam int MAX_CYC = (MAX_ON > GAP_CYCLES) ? MAX_ON : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ON_SLOW  = CNT_W'(ON_CYCLES_SLOW);
    localparam logic [CNT_W-1:0] ON_FAST  = CNT_W'(ON_CYCLES_FAST);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
    localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_ON    = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]     index_q, index_d;
    logic [ADDR_WIDTH:0]       len_q, len_d;
    logic                      speed_q, speed_d;
    logic [COLOR_CODEFY_W-1:0] colour_q, colour_d;
    logic                      last_colour;

    assign last_colour = ({1'b0, index_q} == (len_q - LEN_ONE));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        index_d  = index_q;
        len_d    = len_q;
        speed_d  = speed_q;
        colour_d = colour_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (seq_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                        len_d   = seq_len;
                        speed_d = speed;
                        index_d = '0;
                    end
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                colour_d = mem_rd_data;
                cnt_d    = speed_q ? ON_FAST : ON_SLOW;
                state_d  = ST_ON;
            end
            ST_ON: begin
                if (cnt_q == CNT_ONE) begin
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q != CNT_ONE) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (last_colour) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + ADDR_WIDTH'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // abort overrides every transition, including a start in the same cycle
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            index_q  <= '0;
            len_q    <= '0;
            speed_q  <= 1'b0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            index_q  <= index_d;
            len_q    <= len_d;
            speed_q  <= speed_d;
            colour_q <= colour_d;
        end
    end

    // index only changes on the way into FETCH, so it doubles as the held read address
    assign mem_addr   = index_q;
    assign mem_rd_en  = (state_q == ST_FETCH);
    assign busy       = (state_q == ST_FETCH) || (state_q == ST_LATCH) ||
                        (state_q == ST_ON)    || (state_q == ST_GAP);
    assign done       = (state_q == ST_DONE);
    assign led_green  = (state_q == ST_ON) && (colour_q == COLOR_CODEFY_W'(0));
    assign led_red    = (state_q == ST_ON) && (colour_q == COLOR_CODEFY_W'(1));
    assign led_blue   = (state_q == ST_ON) && (colour_q == COLOR_CODEFY_W'(2));
    assign led_yellow = (state_q == ST_ON) && (colour_q == COLOR_CODEFY_W'(3));

endmodule

// File: tb/tb_sequence_player.sv
// Scoreboard bench for sequence_player: drivers push expected read/LED/done events with
// their cycle numbers, a negedge monitor pops and compares whatever the player shows.
module tb_sequence_player;

    localparam int AW = 5;
    localparam int CW = 2;
    localparam logic [1:0] K_RD   = 2'd0;
    localparam logic [1:0] K_ON   = 2'd1;
    localparam logic [1:0] K_OFF  = 2'd2;
    localparam logic [1:0] K_DONE = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          speed = 1'b0;
    logic [AW:0]   seq_len = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_rd_data = '0;
    logic          led_green, led_red, led_blue, led_yellow;
    logic          busy, done;

    logic [CW-1:0] mem [0:31];
    logic [31:0]   exp_q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    int            busy_from = 1;
    int            busy_to = 0;
    int            last_cur = 0;
    int            last_p = 0;
    int            t = 0;
    logic [3:0]    leds;
    logic [3:0]    prev_leds = '0;
    logic          exp_busy;

    sequence_player dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .speed(speed),
        .seq_len(seq_len), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .led_green(led_green), .led_red(led_red),
        .led_blue(led_blue), .led_yellow(led_yellow), .busy(busy), .done(done)
    );

    // clock / reset / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read sequence memory
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    function automatic logic [31:0] mk_ev(input logic [1:0] k, input logic [5:0] d, input int c);
        return {k, d, c[23:0]};
    endfunction

    function automatic logic [1:0] code_of(input logic [3:0] l);
        case (l)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic observe(input logic [1:0] k, input logic [5:0] d);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d data=%0d cycle=%0d required=none", k, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e !== mk_ev(k, d, cyc)) begin
                failures++;
                $display("FAIL event actual kind=%0d data=%0d cycle=%0d required kind=%0d data=%0d cycle=%0d",
                         k, d, cyc, e[31:30], e[29:24], e[23:0]);
            end
        end
    endtask

    // monitor
    always @(negedge clk) begin
        leds = {led_yellow, led_blue, led_red, led_green};
        if (mon_en) begin
            while (exp_q.size() > 0 && int'(exp_q[0][23:0]) < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_event kind=%0d data=%0d actual=absent required_cycle=%0d",
                         exp_q[0][31:30], exp_q[0][29:24], exp_q[0][23:0]);
                exp_q.delete(0);
            end
            if (mem_rd_en) observe(K_RD, {1'b0, mem_addr});
            if (leds != 4'd0 && prev_leds == 4'd0) observe(K_ON, {4'd0, code_of(leds)});
            if (leds == 4'd0 && prev_leds != 4'd0) observe(K_OFF, 6'd0);
            if (done) observe(K_DONE, 6'd0);
            checks++;
            if ($countones(leds) > 1 || (leds != 4'd0 && prev_leds != 4'd0 && leds != prev_leds)) begin
                failures++;
                $display("FAIL led_onehot actual=%b previous=%b required=one_stable_led_or_zero", leds, prev_leds);
            end
            exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL busy cycle=%0d actual=%b required=%b", cyc, busy, exp_busy);
            end
        end
        prev_leds = leds;
    end

    // drivers: every task returns 1 time unit after a rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int tc);
        while (cyc < tc) next_cycle();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) mem[i] = 2'($urandom);
    endtask

    // Reference: colour i is read at cur+1+i*P, lit 2 cycles later for ON cycles, done follows the last gap.
    task automatic start_play(input int len, input bit spd);
        int cur, on, p, base;
        next_cycle();
        cur = cyc;
        start = 1'b1;
        speed = spd;
        seq_len = len[AW:0];
        on = spd ? 2 : 4;
        p = 2 + on + 2;
        for (int i = 0; i < len; i++) begin
            base = cur + 1 + i * p;
            exp_q.push_back(mk_ev(K_RD, i[5:0], base));
            exp_q.push_back(mk_ev(K_ON, {4'd0, mem[i]}, base + 2));
            exp_q.push_back(mk_ev(K_OFF, 6'd0, base + 2 + on));
        end
        exp_q.push_back(mk_ev(K_DONE, 6'd0, cur + 1 + len * p));
        busy_from = cur + 1;
        busy_to = cur + len * p;
        last_cur = cur;
        last_p = p;
        next_cycle();
        start = 1'b0;
        speed = 1'($urandom);
        seq_len = 6'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            next_cycle();
            speed = 1'($urandom);
            seq_len = 6'($urandom);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL playback_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) next_cycle();
    endtask

    task automatic flush_after(input int tc);
        logic [31:0] keep[$];
        foreach (exp_q[i]) if (int'(exp_q[i][23:0]) <= tc) keep.push_back(exp_q[i]);
        exp_q = keep;
    endtask

    initial begin
        repeat (3) next_cycle();
        check("reset_leds", 32'({led_yellow, led_blue, led_red, led_green}), 32'd0);
        check("reset_busy_done_rd", 32'({busy, done, mem_rd_en}), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        next_cycle();

        // fixed colours, slow then fast
        for (int i = 0; i < 32; i++) mem[i] = 2'(i);
        start_play(4, 1'b0);
        wait_idle(100);
        start_play(4, 1'b1);
        wait_idle(100);

        // empty sequence and full-depth sequence
        start_play(0, 1'($urandom));
        wait_idle(10);
        fill_random();
        start_play(32, 1'b1);
        wait_idle(400);

        // abort in the middle of the second colour's on-time
        fill_random();
        start_play(4, 1'b0);
        t = last_cur + 1 + last_p + 3;
        goto_cycle(t);
        abort = 1'b1;
        flush_after(t);
        exp_q.push_back(mk_ev(K_OFF, 6'd0, t + 1));
        busy_to = t;
        next_cycle();
        abort = 1'b0;
        check("abort_leds", 32'({led_yellow, led_blue, led_red, led_green}), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        wait_idle(20);

        // start and abort together: nothing may happen
        start = 1'b1;
        abort = 1'b1;
        seq_len = 6'd4;
        next_cycle();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        repeat (12) next_cycle();

        // restart attempts while busy and while in DONE are ignored
        fill_random();
        start_play(3, 1'b0);
        goto_cycle(last_cur + 5);
        start = 1'b1;
        seq_len = 6'd7;
        speed = 1'b1;
        next_cycle();
        start = 1'b0;
        goto_cycle(last_cur + 1 + 3 * last_p);
        start = 1'b1;
        seq_len = 6'd2;
        next_cycle();
        start = 1'b0;
        wait_idle(100);

        // reset held two cycles during the second colour's on-time
        fill_random();
        start_play(4, 1'b0);
        t = last_cur + 1 + last_p + 3;
        goto_cycle(t);
        rst = 1'b1;
        flush_after(t);
        exp_q.push_back(mk_ev(K_OFF, 6'd0, t + 1));
        busy_to = t;
        next_cycle();
        check("rst_leds", 32'({led_yellow, led_blue, led_red, led_green}), 32'd0);
        check("rst_busy_done_rd", 32'({busy, done, mem_rd_en}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        next_cycle();
        rst = 1'b0;
        wait_idle(20);

        // randomized playbacks
        repeat (10) begin
            int len;
            fill_random();
            len = $urandom_range(0, 32);
            start_play(len, 1'($urandom));
            wait_idle(len * 8 + 20);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
